// File: rtl/fpga_config_writer.sv
// Builds the connection-configuration image in RAM: 44-byte little-endian records
// from 0x10 upward, then the 16-byte header at 0x0 once the image is closed.
module fpga_config_writer #(
  parameter int MAX_CONNECTIONS = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic [31:0]           version,
  input  logic [31:0]           timestamp,
  input  logic                  conn_valid,
  output logic                  conn_ready,
  input  logic [31:0]           conn_switch_id,
  input  logic [31:0]           conn_host_id,
  input  logic [31:0]           conn_my_ip,
  input  logic [31:0]           conn_peer_ip,
  input  logic [15:0]           conn_my_port,
  input  logic [15:0]           conn_peer_port,
  input  logic [15:0]           conn_my_qp,
  input  logic [15:0]           conn_peer_qp,
  input  logic [47:0]           conn_my_mac,
  input  logic [47:0]           conn_peer_mac,
  input  logic                  conn_up,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_error,
  output logic [6:0]            conn_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ACCEPT     = 3'd1;
  localparam logic [2:0] S_WRITE_CONN = 3'd2;
  localparam logic [2:0] S_WRITE_HDR  = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic [31:0] HDR_MAGIC = 32'h4154_4746;
  localparam logic [6:0]  MAX_CNT   = 7'(MAX_CONNECTIONS);

  logic [2:0]            state;
  logic [3:0]            word_idx;
  logic [3:0]            idx_next;
  logic                  finish_pending;
  logic [31:0]           hdr_version;
  logic [31:0]           hdr_timestamp;
  logic [DATA_WIDTH-1:0] hdr_next;
  logic [DATA_WIDTH-1:0] rec_words [0:10];
  logic [DATA_WIDTH-1:0] rec_buf   [0:10];
  logic [ADDR_WIDTH-1:0] rec_base;
  logic                  handshake;
  logic                  wr_done;

  // MAC byte0 is the most significant octet, so it lands at the lowest address.
  always_comb begin
    rec_words[0]  = conn_switch_id;
    rec_words[1]  = conn_host_id;
    rec_words[2]  = conn_my_ip;
    rec_words[3]  = conn_peer_ip;
    rec_words[4]  = {conn_peer_port, conn_my_port};
    rec_words[5]  = {conn_peer_qp, conn_my_qp};
    rec_words[6]  = {conn_my_mac[23:16], conn_my_mac[31:24],
                     conn_my_mac[39:32], conn_my_mac[47:40]};
    rec_words[7]  = {conn_peer_mac[39:32], conn_peer_mac[47:40],
                     conn_my_mac[7:0], conn_my_mac[15:8]};
    rec_words[8]  = {conn_peer_mac[7:0], conn_peer_mac[15:8],
                     conn_peer_mac[23:16], conn_peer_mac[31:24]};
    rec_words[9]  = {31'h0, conn_up};
    rec_words[10] = '0;
  end

  assign conn_ready = (state == S_ACCEPT) && (conn_count < MAX_CNT);
  assign handshake  = conn_ready && conn_valid;
  assign wr_done    = mem_we && mem_ready;
  assign busy       = (state == S_ACCEPT) || (state == S_WRITE_CONN) || (state == S_WRITE_HDR);
  assign done       = (state == S_DONE);
  assign idx_next   = word_idx + 4'd1;
  assign rec_base   = ADDR_WIDTH'(16) + ADDR_WIDTH'(conn_count) * ADDR_WIDTH'(44);

  always_comb begin
    hdr_next = HDR_MAGIC;
    case (idx_next[1:0])
      2'd1:    hdr_next = hdr_version;
      2'd2:    hdr_next = {25'h0, conn_count};
      2'd3:    hdr_next = hdr_timestamp;
      default: hdr_next = HDR_MAGIC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (handshake) rec_buf <= rec_words;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      word_idx       <= '0;
      finish_pending <= 1'b0;
      hdr_version    <= '0;
      hdr_timestamp  <= '0;
      conn_count     <= '0;
      overflow_error <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_ACCEPT;
            conn_count     <= '0;
            overflow_error <= 1'b0;
            finish_pending <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (conn_valid && !conn_ready) overflow_error <= 1'b1;
          if (finish) begin
            hdr_version   <= version;
            hdr_timestamp <= timestamp;
          end
          // w0 goes out straight from the inputs; the buffer feeds w1..w10.
          if (handshake) begin
            conn_count     <= conn_count + 7'd1;
            finish_pending <= finish;
            word_idx       <= '0;
            mem_we         <= 1'b1;
            mem_addr       <= rec_base;
            mem_wdata      <= rec_words[0];
            state          <= S_WRITE_CONN;
          end else if (finish) begin
            word_idx  <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= HDR_MAGIC;
            state     <= S_WRITE_HDR;
          end
        end
        S_WRITE_CONN: begin
          if (wr_done) begin
            if (word_idx == 4'd10) begin
              word_idx <= '0;
              if (finish_pending) begin
                finish_pending <= 1'b0;
                mem_addr       <= '0;
                mem_wdata      <= HDR_MAGIC;
                state          <= S_WRITE_HDR;
              end else begin
                mem_we <= 1'b0;
                state  <= S_ACCEPT;
              end
            end else begin
              word_idx  <= idx_next;
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= rec_buf[idx_next];
            end
          end
        end
        S_WRITE_HDR: begin
          if (wr_done) begin
            if (word_idx == 4'd3) begin
              mem_we <= 1'b0;
              state  <= S_DONE;
            end else begin
              word_idx  <= idx_next;
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= hdr_next;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_writer.sv
// Bench for fpga_config_writer: directed vector table plus randomized images checked
// against a byte-image reference model of the RAM contents.
module tb_fpga_config_writer;

  typedef struct packed {
    logic [31:0] sw;
    logic [31:0] host;
    logic [31:0] my_ip;
    logic [31:0] peer_ip;
    logic [15:0] my_port;
    logic [15:0] peer_port;
    logic [15:0] my_qp;
    logic [15:0] peer_qp;
    logic [47:0] my_mac;
    logic [47:0] peer_mac;
    logic        up;
  } rec_t;

  typedef struct {
    rec_t              rec;
    logic [31:0]       ver;
    logic [31:0]       ts;
    int unsigned       mode;
    logic [0:10][31:0] exp_w;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0, finish = 1'b0, conn_valid = 1'b0, conn_up = 1'b0;
  logic [31:0] version = '0, timestamp = '0;
  logic [31:0] conn_switch_id = '0, conn_host_id = '0, conn_my_ip = '0, conn_peer_ip = '0;
  logic [15:0] conn_my_port = '0, conn_peer_port = '0, conn_my_qp = '0, conn_peer_qp = '0;
  logic [47:0] conn_my_mac = '0, conn_peer_mac = '0;
  logic        conn_ready, mem_we, busy, done, overflow_error;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0]  conn_count;

  int unsigned errors = 0, checks = 0;
  logic [63:0] cap_q[$];
  logic [63:0] exp_q[$];
  int unsigned we_cycles = 0, done_cnt = 0, rdy_mode = 0;
  logic        stall_pending = 1'b0;
  logic [31:0] held_addr = '0, held_data = '0;

  fpga_config_writer #(.MAX_CONNECTIONS(64), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .version(version), .timestamp(timestamp),
    .conn_valid(conn_valid), .conn_ready(conn_ready),
    .conn_switch_id(conn_switch_id), .conn_host_id(conn_host_id),
    .conn_my_ip(conn_my_ip), .conn_peer_ip(conn_peer_ip),
    .conn_my_port(conn_my_port), .conn_peer_port(conn_peer_port),
    .conn_my_qp(conn_my_qp), .conn_peer_qp(conn_peer_qp),
    .conn_my_mac(conn_my_mac), .conn_peer_mac(conn_peer_mac), .conn_up(conn_up),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done), .overflow_error(overflow_error), .conn_count(conn_count)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Memory-side observer: captures completed writes and checks words are held under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("hold_we", mem_we, 1);
        chk("hold_addr_data", {mem_addr, mem_wdata}, {held_addr, held_data});
      end
      if (mem_we) we_cycles++;
      if (mem_we && mem_ready) cap_q.push_back({mem_addr, mem_wdata});
      if (done) done_cnt++;
      stall_pending = mem_we && !mem_ready;
      held_addr = mem_addr;
      held_data = mem_wdata;
    end
  end

  // mode 0: always ready; mode 1: every word stalls exactly one cycle; mode 2: random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = stall_pending;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic rec_t mk_rec(input logic [31:0] sw, host, mip, pip,
                                  input logic [15:0] mp, pp, mq, pq,
                                  input logic [47:0] mm, pm, input logic up);
    rec_t r;
    r.sw = sw; r.host = host; r.my_ip = mip; r.peer_ip = pip;
    r.my_port = mp; r.peer_port = pp; r.my_qp = mq; r.peer_qp = pq;
    r.my_mac = mm; r.peer_mac = pm; r.up = up;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    return mk_rec($urandom, $urandom, $urandom, $urandom,
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  48'({$urandom, $urandom}), 48'({$urandom, $urandom}),
                  1'($urandom_range(0, 1)));
  endfunction

  // Reference: lay the record out as its 44-byte little-endian image, then read it back as words.
  function automatic void model_rec(input rec_t r, input int unsigned n);
    byte unsigned b[44];
    for (int i = 0; i < 44; i++) b[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      b[i]      = r.sw[8*i +: 8];
      b[4 + i]  = r.host[8*i +: 8];
      b[8 + i]  = r.my_ip[8*i +: 8];
      b[12 + i] = r.peer_ip[8*i +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      b[16 + i] = r.my_port[8*i +: 8];
      b[18 + i] = r.peer_port[8*i +: 8];
      b[20 + i] = r.my_qp[8*i +: 8];
      b[22 + i] = r.peer_qp[8*i +: 8];
    end
    for (int i = 0; i < 6; i++) begin
      b[24 + i] = r.my_mac[8*(5-i) +: 8];
      b[30 + i] = r.peer_mac[8*(5-i) +: 8];
    end
    b[36] = {7'h0, r.up};
    for (int k = 0; k < 11; k++)
      exp_q.push_back({32'(16 + n*44 + 4*k), b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
  endfunction

  function automatic void model_hdr(input logic [31:0] v, input logic [31:0] t, input int unsigned n);
    exp_q.push_back({32'h0, 32'h4154_4746});
    exp_q.push_back({32'h4, v});
    exp_q.push_back({32'h8, 32'(n)});
    exp_q.push_back({32'hC, t});
  endfunction

  function automatic void compare_image();
    int unsigned n;
    chk("n_writes", cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) chk($sformatf("wr%0d", i), cap_q[i], exp_q[i]);
  endfunction

  task automatic clear_obs();
    cap_q.delete();
    exp_q.delete();
    we_cycles = 0;
  endtask

  task automatic start_image();
    @(negedge clk);
    for (int i = 0; i < 100 && (busy || done); i++) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_ready", conn_ready, 1);
    chk("start_count", conn_count, 0);
    chk("start_ovf", overflow_error, 0);
  endtask

  task automatic send_rec(input rec_t r, input logic fin, input logic [31:0] base);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (conn_ready) begin
        ok = 1;
        conn_switch_id = r.sw;     conn_host_id   = r.host;
        conn_my_ip     = r.my_ip;  conn_peer_ip   = r.peer_ip;
        conn_my_port   = r.my_port; conn_peer_port = r.peer_port;
        conn_my_qp     = r.my_qp;  conn_peer_qp   = r.peer_qp;
        conn_my_mac    = r.my_mac; conn_peer_mac  = r.peer_mac;
        conn_up        = r.up;
        conn_valid     = 1'b1;
        finish         = fin;
      end
    end
    chk("ready_wait", ok, 1);
    @(posedge clk); #1;
    conn_valid = 1'b0;
    finish     = 1'b0;
    @(negedge clk);
    chk("ready_drop", conn_ready, 0);
    chk("w0_we", mem_we, 1);
    chk("w0_addr", mem_addr, base);
  endtask

  task automatic do_finish(input logic [31:0] v, input logic [31:0] t);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (busy && !mem_we) begin
        ok = 1;
        version = v; timestamp = t; finish = 1'b1;
      end
    end
    chk("accept_wait", ok, 1);
    @(posedge clk); #1;
    finish = 1'b0;
    version = $urandom;
    timestamp = $urandom;
  endtask

  task automatic wait_done();
    bit ok = 0;
    int unsigned c0 = done_cnt;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    chk("done_seen", ok, 1);
    chk("busy_in_done", busy, 0);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_pulses", done_cnt - c0, 1);
  endtask

  initial begin : main
    vec_t        vecs[4];
    rec_t        r;
    int unsigned cnt, nrec;
    logic [31:0] sv, st;
    bit          ok, sim;

    vecs[0].rec  = mk_rec(32'd1, 32'd2, 32'h0A00_0001, 32'h0A00_0002, 16'd4791, 16'd4792,
                          16'h11, 16'h12, 48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b1);
    vecs[0].ver  = 32'd1; vecs[0].ts = 32'h6500_0000; vecs[0].mode = 0;
    vecs[0].exp_w = {32'h1, 32'h2, 32'h0A00_0001, 32'h0A00_0002, 32'h12B8_12B7, 32'h0012_0011,
                     32'h3322_1100, 32'h7766_5544, 32'hBBAA_9988, 32'h1, 32'h0};
    vecs[1] = vecs[0];
    vecs[1].mode = 1;
    vecs[2].rec  = mk_rec('1, '1, '1, '1, '1, '1, '1, '1, '1, '1, 1'b1);
    vecs[2].ver  = 32'hFFFF_FFFF; vecs[2].ts = 32'h0; vecs[2].mode = 0;
    vecs[2].exp_w = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0};
    vecs[3].rec  = mk_rec(32'hDEAD_BEEF, 32'h0, 32'h0102_0304, 32'hC0A8_0001, 16'hAAAA, 16'h5555,
                          16'h1234, 16'hABCD, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 1'b0);
    vecs[3].ver  = 32'h0000_0002; vecs[3].ts = 32'h1234_5678; vecs[3].mode = 1;
    vecs[3].exp_w = {32'hDEAD_BEEF, 32'h0, 32'h0102_0304, 32'hC0A8_0001, 32'h5555_AAAA,
                     32'hABCD_1234, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h0, 32'h0};

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom); finish = 1'($urandom); conn_valid = 1'($urandom);
      conn_switch_id = $urandom; version = $urandom; timestamp = $urandom;
      @(negedge clk);
      chk("rst_addr", mem_addr, 0);     chk("rst_wdata", mem_wdata, 0);
      chk("rst_we", mem_we, 0);         chk("rst_ready", conn_ready, 0);
      chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
      chk("rst_ovf", overflow_error, 0); chk("rst_count", conn_count, 0);
    end
    start = 1'b0; finish = 1'b0; conn_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int v = 0; v < 4; v++) begin
      rdy_mode = vecs[v].mode;
      start_image();
      clear_obs();
      send_rec(vecs[v].rec, 1'b0, 32'h10);
      cnt = 1; ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        cnt++;
        ok = conn_ready;
      end
      chk($sformatf("v%0d_ready_return", v), cnt, (vecs[v].mode == 1) ? 23 : 12);
      do_finish(vecs[v].ver, vecs[v].ts);
      wait_done();
      chk($sformatf("v%0d_n_writes", v), cap_q.size(), 15);
      if (cap_q.size() == 15) begin
        for (int k = 0; k < 11; k++)
          chk($sformatf("v%0d_w%0d", v, k), cap_q[k], {32'(16 + 4*k), vecs[v].exp_w[k]});
        chk($sformatf("v%0d_magic", v), cap_q[11], {32'h0, 32'h4154_4746});
        chk($sformatf("v%0d_ver", v), cap_q[12], {32'h4, vecs[v].ver});
        chk($sformatf("v%0d_cnt", v), cap_q[13], {32'h8, 32'h1});
        chk($sformatf("v%0d_ts", v), cap_q[14], {32'hC, vecs[v].ts});
      end
      chk($sformatf("v%0d_we_cycles", v), we_cycles, (vecs[v].mode == 1) ? 30 : 15);
    end

    // Finish with zero records.
    rdy_mode = 0;
    start_image();
    clear_obs();
    do_finish(32'h7, 32'h8);
    model_hdr(32'h7, 32'h8, 0);
    wait_done();
    compare_image();

    // Record and finish in the same cycle; header fields sampled then.
    start_image();
    clear_obs();
    r = rand_rec();
    version = 32'hA5A5_0001; timestamp = 32'h5A5A_0002;
    send_rec(r, 1'b1, 32'h10);
    version = $urandom; timestamp = $urandom;
    model_rec(r, 0);
    model_hdr(32'hA5A5_0001, 32'h5A5A_0002, 1);
    wait_done();
    compare_image();

    // start/finish during WRITE_CONN are ignored.
    start_image();
    clear_obs();
    r = rand_rec();
    send_rec(r, 1'b0, 32'h10);
    start = 1'b1; finish = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; finish = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = conn_ready;
    end
    chk("ign_ready", ok, 1);
    chk("ign_count", conn_count, 1);
    chk("ign_no_hdr", cap_q.size(), 11);
    model_rec(r, 0);
    do_finish(32'h33, 32'h44);
    model_hdr(32'h33, 32'h44, 1);
    wait_done();
    compare_image();

    // Capacity and overflow.
    start_image();
    clear_obs();
    for (int unsigned n = 0; n < 64; n++) begin
      r = rand_rec();
      send_rec(r, 1'b0, 32'(16 + n*44));
      model_rec(r, n);
      chk("cap_count", conn_count, n + 1);
    end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = busy && !mem_we;
    end
    chk("full_accept", ok, 1);
    chk("full_ready", conn_ready, 0);
    chk("full_ovf_pre", overflow_error, 0);
    conn_valid = 1'b1;
    @(posedge clk); #1;
    conn_valid = 1'b0;
    @(negedge clk);
    chk("full_ovf", overflow_error, 1);
    chk("full_count", conn_count, 64);
    do_finish(32'h9, 32'hA);
    model_hdr(32'h9, 32'hA, 64);
    wait_done();
    compare_image();
    chk("ovf_sticky", overflow_error, 1);

    // Asynchronous reset during w5.
    start_image();
    clear_obs();
    r = rand_rec();
    send_rec(r, 1'b0, 32'h10);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = mem_we && (mem_addr == 32'h24);
      if (!ok) @(negedge clk);
    end
    chk("w5_seen", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", conn_count, 0);
    chk("arst_ready", conn_ready, 0);
    #2;
    rst_n = 1'b1;
    start_image();
    clear_obs();
    r = rand_rec();
    send_rec(r, 1'b0, 32'h10);
    model_rec(r, 0);
    do_finish(32'h5, 32'h6);
    model_hdr(32'h5, 32'h6, 1);
    wait_done();
    compare_image();

    // Randomized images under random backpressure.
    for (int img = 0; img < 4; img++) begin
      rdy_mode = 2;
      start_image();
      clear_obs();
      nrec = $urandom_range(1, 6);
      sim = 0;
      sv = $urandom; st = $urandom;
      for (int unsigned j = 0; j < nrec; j++) begin
        r = rand_rec();
        sim = (j == nrec - 1) && ($urandom_range(0, 1) == 1);
        if (sim) begin
          version = sv; timestamp = st;
        end
        send_rec(r, sim, 32'(16 + j*44));
        model_rec(r, j);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      if (!sim) do_finish(sv, st);
      model_hdr(sv, st, nrec);
      wait_done();
      compare_image();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
